// File: rtl/imm_ext_stage.sv
// ID/EX immediate-extension stage: extends a 16-bit immediate to 32 bits and
// buffers it behind a valid/ready handshake with a 2-entry skid buffer.
// Optional: define IMM_BRANCH_SHIFT_EN to make mode 11 emit the branch byte offset.
module imm_ext_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [31:0]      ext_data;
  logic [31:0]      main_data, skid_data;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             main_valid, skid_valid;
  logic             in_xfer, out_xfer;

  // Extension is done before storage so the registered output is ready to use.
  always_comb begin
    ext_data = {{16{in_imm[15]}}, in_imm};
    case (in_mode)
      2'b01:   ext_data = {16'h0, in_imm};
      2'b10:   ext_data = {in_imm, 16'h0};
`ifdef IMM_BRANCH_SHIFT_EN
      2'b11:   ext_data = {{14{in_imm[15]}}, in_imm, 2'b00};
`else
      2'b11:   ext_data = {{16{in_imm[15]}}, in_imm};
`endif
      default: ext_data = {{16{in_imm[15]}}, in_imm};
    endcase
  end

  assign in_ready  = !skid_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

  // Skid only fills while main is stalled, so in_ready is low whenever skid holds data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= 32'h0;
      main_tag   <= '0;
      skid_data  <= 32'h0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_xfer) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_tag   <= skid_tag;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_data  <= ext_data;
        main_tag   <= in_tag;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed scenarios plus a random
// handshake run against a scoreboard FIFO. Honours IMM_BRANCH_SHIFT_EN.
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = 16'h0;
  logic [1:0]  in_mode = 2'b00;
  logic [4:0]  in_tag = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int checks = 0;
  int failures = 0;

  imm_ext_stage #(.TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00: return {{16{imm[15]}}, imm};
      2'b01: return {16'h0000, imm};
      2'b10: return {imm, 16'h0000};
`ifdef IMM_BRANCH_SHIFT_EN
      default: return {{14{imm[15]}}, imm, 2'b00};
`else
      default: return {{16{imm[15]}}, imm};
`endif
    endcase
  endfunction

  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=00000000", out_data); end
    checks++; if (out_tag !== 5'd0) begin failures++; $display("[TB] FAIL reset_out_tag got=%0d exp=0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset got=%0b exp=0", out_valid); end
  endtask

  task automatic test_modes();
    logic [31:0] exp_d [4];
    logic [1:0]  modes [4];
    logic [15:0] imms  [4];
    exp_d[0] = 32'hFFFF8241; exp_d[1] = 32'h00008241; exp_d[2] = 32'h82410000;
`ifdef IMM_BRANCH_SHIFT_EN
    exp_d[3] = 32'hFFFFFFFC;
`else
    exp_d[3] = 32'hFFFFFFFF;
`endif
    modes[0] = 2'b00; modes[1] = 2'b01; modes[2] = 2'b10; modes[3] = 2'b11;
    imms[0] = 16'h8241; imms[1] = 16'h8241; imms[2] = 16'h8241; imms[3] = 16'hFFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(imms[i], modes[i], 5'(i + 1));
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mode%0d_valid got=%0b exp=1", i, out_valid); end
      checks++; if (out_data !== exp_d[i]) begin failures++; $display("[TB] FAIL mode%0d_data got=%h exp=%h", i, out_data, exp_d[i]); end
      checks++; if (out_tag !== 5'(i + 1)) begin failures++; $display("[TB] FAIL mode%0d_tag got=%0d exp=%0d", i, out_tag, i + 1); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL modes_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(16'h0001, 2'b01, 5'd1);
    tick();
    checks++; if (out_tag !== 5'd1 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_first got=v%0b/t%0d exp=v1/t1", out_valid, out_tag); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready1 got=%0b exp=1", in_ready); end
    send(16'h0002, 2'b01, 5'd2);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready2 got=%0b exp=0", in_ready); end
    send(16'h0003, 2'b01, 5'd3);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready3 got=%0b exp=0", in_ready); end
    checks++; if (out_tag !== 5'd1 || out_data !== 32'h1) begin failures++; $display("[TB] FAIL bp_hold got=t%0d/%h exp=t1/00000001", out_tag, out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_tag !== 5'd2 || out_data !== 32'h2) begin failures++; $display("[TB] FAIL bp_order2 got=t%0d/%h exp=t2/00000002", out_tag, out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_back got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_tag !== 5'd3 || out_data !== 32'h3 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_order3 got=v%0b/t%0d/%h exp=v1/t3/00000003", out_valid, out_tag, out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_nodup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(16'h0005, 2'b00, 5'd5);
    tick();
    send(16'h0006, 2'b00, 5'd6);
    tick();
    send(16'h0007, 2'b00, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    // One entry held, flush while in_ready=1: input must be discarded too.
    send(16'h0008, 2'b00, 5'd8);
    tick();
    out_ready = 1'b0;
    send(16'h0007, 2'b00, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_tag7_leak cyc=%0d got=v%0b/t%0d exp=v0", i, out_valid, out_tag); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(16'h1234, 2'b01, 5'd9);
    tick();
    send(16'h5678, 2'b01, 5'd10);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL arst_data got=%h exp=00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL arst_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_quiet got=%0b exp=0", out_valid); end
    out_ready = 1'b1;
    send(16'h00AB, 2'b10, 5'd11);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00AB0000 || out_tag !== 5'd11) begin failures++; $display("[TB] FAIL arst_latency got=v%0b/t%0d/%h exp=v1/t11/00ab0000", out_valid, out_tag, out_data); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q_data[$];
    logic [4:0]  q_tag[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;
    prev_stall = 1'b0; prev_data = 32'h0; prev_tag = 5'd0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = 5'($urandom_range(0, 31));
      if (out_valid && out_ready) begin
        checks++;
        if (q_data.size() == 0) begin
          failures++; $display("[TB] FAIL rand_spurious cyc=%0d got=t%0d exp=none", i, out_tag);
        end else begin
          if (out_data !== q_data[0] || out_tag !== q_tag[0]) begin
            failures++; $display("[TB] FAIL rand_order cyc=%0d got=t%0d/%h exp=t%0d/%h", i, out_tag, out_data, q_tag[0], q_data[0]);
          end
          void'(q_data.pop_front()); void'(q_tag.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q_data.push_back(model_ext(in_imm, in_mode));
        q_tag.push_back(in_tag);
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_tag = out_tag;
      tick();
      checks++; if (out_valid !== (q_data.size() > 0)) begin failures++; $display("[TB] FAIL rand_valid cyc=%0d got=%0b exp=%0b", i, out_valid, q_data.size() > 0); end
      checks++; if (in_ready !== (q_data.size() < 2)) begin failures++; $display("[TB] FAIL rand_ready cyc=%0d got=%0b exp=%0b", i, in_ready, q_data.size() < 2); end
      if (prev_stall) begin
        checks++; if (out_data !== prev_data || out_tag !== prev_tag) begin failures++; $display("[TB] FAIL rand_stable cyc=%0d got=t%0d/%h exp=t%0d/%h", i, out_tag, out_data, prev_tag, prev_data); end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    $display("[TB] imm_ext_stage bench start");
    test_reset();
    test_modes();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
